// File: rtl/armleocpu_pagefault_unit_pkg.sv
// Shared definitions for the ArmleoCPU page-fault unit: command and privilege
// encodings, PTE metadata bit positions, fault causes and FSM states.
package armleocpu_pagefault_unit_pkg;

    localparam logic [3:0] CACHE_CMD_NONE    = 4'd0;
    localparam logic [3:0] CACHE_CMD_EXECUTE = 4'd1;
    localparam logic [3:0] CACHE_CMD_LOAD    = 4'd2;
    localparam logic [3:0] CACHE_CMD_STORE   = 4'd3;

    localparam logic [1:0] ARMLEOCPU_PRIVILEGE_USER       = 2'd0;
    localparam logic [1:0] ARMLEOCPU_PRIVILEGE_SUPERVISOR = 2'd1;
    localparam logic [1:0] ARMLEOCPU_PRIVILEGE_MACHINE    = 2'd3;

    localparam logic [2:0] ARMLEOCPU_PF_NONE       = 3'd0;
    localparam logic [2:0] ARMLEOCPU_PF_INVALID    = 3'd1;
    localparam logic [2:0] ARMLEOCPU_PF_PRIVILEGE  = 3'd2;
    localparam logic [2:0] ARMLEOCPU_PF_PERMISSION = 3'd3;
    localparam logic [2:0] ARMLEOCPU_PF_ACCESS     = 3'd4;
    localparam logic [2:0] ARMLEOCPU_PF_DIRTY      = 3'd5;
    localparam logic [2:0] ARMLEOCPU_PF_AD_ERR     = 3'd6;

    localparam int PTE_V = 0;
    localparam int PTE_R = 1;
    localparam int PTE_W = 2;
    localparam int PTE_X = 3;
    localparam int PTE_U = 4;
    localparam int PTE_G = 5;
    localparam int PTE_A = 6;
    localparam int PTE_D = 7;

    typedef struct packed {
        logic       satp_mode;
        logic       mprv;
        logic       mxr;
        logic       sum;
        logic [1:0] mpp;
        logic [1:0] privilege;
    } csr_snapshot_t;

    typedef enum logic [2:0] {
        STATE_IDLE,
        STATE_CHECK,
        STATE_AD_REQ,
        STATE_AD_WAIT,
        STATE_RESP
    } state_t;

endpackage

// File: rtl/armleocpu_pagefault_unit_if.sv
// Request, response and PTE A/D update signals of the page-fault unit.
// The slave modport is the unit itself; master is the surrounding MMU logic.
interface armleocpu_pagefault_unit_if #(
    parameter int CHANNELS   = 2,
    parameter int PTE_ADDR_W = 34
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CHANNELS-1:0]            req_valid;
    logic [CHANNELS-1:0]            req_ready;
    logic [CHANNELS*4-1:0]          req_cmd;
    logic [CHANNELS*8-1:0]          req_metadata;
    logic [CHANNELS*PTE_ADDR_W-1:0] req_pte_addr;

    logic                           resp_valid;
    logic [CH_W-1:0]                resp_channel;
    logic                           resp_pagefault;
    logic [2:0]                     resp_cause;

    logic                           ad_valid;
    logic                           ad_ready;
    logic [PTE_ADDR_W-1:0]          ad_addr;
    logic                           ad_set_dirty;
    logic                           ad_done;
    logic                           ad_err;

    modport master (
        output req_valid, req_cmd, req_metadata, req_pte_addr,
        output ad_ready, ad_done, ad_err,
        input  req_ready, resp_valid, resp_channel, resp_pagefault, resp_cause,
        input  ad_valid, ad_addr, ad_set_dirty
    );

    modport slave (
        input  req_valid, req_cmd, req_metadata, req_pte_addr,
        input  ad_ready, ad_done, ad_err,
        output req_ready, resp_valid, resp_channel, resp_pagefault, resp_cause,
        output ad_valid, ad_addr, ad_set_dirty
    );

endinterface

// File: rtl/armleocpu_pagefault_rules.sv
// Combinational Sv32 permission evaluation: returns the first matching fault
// cause, or flags that the A/D bits must be updated by hardware.
module armleocpu_pagefault_rules
    import armleocpu_pagefault_unit_pkg::*;
#(
    parameter int HW_AD_UPDATE = 0
) (
    input  logic [3:0]    cmd,
    input  logic [7:0]    metadata,
    input  csr_snapshot_t csr,
    output logic [2:0]    cause,
    output logic          ad_needed
);

    logic [1:0] eff_priv;
    logic       need_a;
    logic       need_d;
    logic       perm_ok;
    logic       unused_global;

    assign unused_global = metadata[PTE_G];

    always_comb begin
        eff_priv = (csr.mprv && cmd != CACHE_CMD_EXECUTE) ? csr.mpp : csr.privilege;
        need_a   = !metadata[PTE_A];
        need_d   = (cmd == CACHE_CMD_STORE) && !metadata[PTE_D];

        case (cmd)
            CACHE_CMD_EXECUTE: perm_ok = metadata[PTE_X];
            CACHE_CMD_LOAD:    perm_ok = metadata[PTE_R] || (csr.mxr && metadata[PTE_X]);
            CACHE_CMD_STORE:   perm_ok = metadata[PTE_W];
            default:           perm_ok = 1'b1;
        endcase

        cause     = ARMLEOCPU_PF_NONE;
        ad_needed = 1'b0;
        // Bare translation, machine mode and idle commands are never checked
        if (!csr.satp_mode || eff_priv == ARMLEOCPU_PRIVILEGE_MACHINE || cmd == CACHE_CMD_NONE) begin
            cause = ARMLEOCPU_PF_NONE;
        end else if (!metadata[PTE_V] || (metadata[PTE_W] && !metadata[PTE_R])) begin
            cause = ARMLEOCPU_PF_INVALID;
        end else if ((metadata[PTE_U] && eff_priv == ARMLEOCPU_PRIVILEGE_SUPERVISOR
                      && (!csr.sum || cmd == CACHE_CMD_EXECUTE))
                  || (!metadata[PTE_U] && eff_priv == ARMLEOCPU_PRIVILEGE_USER)) begin
            cause = ARMLEOCPU_PF_PRIVILEGE;
        end else if (!perm_ok) begin
            cause = ARMLEOCPU_PF_PERMISSION;
        end else if (HW_AD_UPDATE != 0) begin
            ad_needed = need_a || need_d;
        end else if (need_a) begin
            cause = ARMLEOCPU_PF_ACCESS;
        end else if (need_d) begin
            cause = ARMLEOCPU_PF_DIRTY;
        end
    end

endmodule

// File: rtl/armleocpu_pagefault_unit.sv
// Round-robin arbitrated, registered page-permission checker with optional
// hardware A/D bit update through a PTE update handshake.
module armleocpu_pagefault_unit
    import armleocpu_pagefault_unit_pkg::*;
#(
    parameter int CHANNELS     = 2,
    parameter int HW_AD_UPDATE = 0,
    parameter int PTE_ADDR_W   = 34
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       csr_satp_mode_r,
    input  logic       csr_mstatus_mprv,
    input  logic       csr_mstatus_mxr,
    input  logic       csr_mstatus_sum,
    input  logic [1:0] csr_mstatus_mpp,
    input  logic [1:0] csr_mcurrent_privilege,
    armleocpu_pagefault_unit_if.slave bus
);

    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    state_t                state_q, state_d;
    logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0]       owner_q, owner_d;
    logic [3:0]            cmd_q, cmd_d;
    logic [7:0]            meta_q, meta_d;
    logic [PTE_ADDR_W-1:0] pte_addr_q, pte_addr_d;
    csr_snapshot_t         csr_q, csr_d;
    logic                  resp_valid_q, resp_valid_d;
    logic                  resp_pagefault_q, resp_pagefault_d;
    logic [2:0]            resp_cause_q, resp_cause_d;
    logic                  ad_valid_q, ad_valid_d;
    logic [PTE_ADDR_W-1:0] ad_addr_q, ad_addr_d;
    logic                  ad_set_dirty_q, ad_set_dirty_d;

    logic [3:0]            cmd_arr  [CHANNELS];
    logic [7:0]            meta_arr [CHANNELS];
    logic [PTE_ADDR_W-1:0] addr_arr [CHANNELS];

    logic                  grant_found;
    logic [CH_W-1:0]       grant_idx;
    logic [CHANNELS-1:0]   req_ready;
    logic [2:0]            rule_cause;
    logic                  rule_ad_needed;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_unpack
        assign cmd_arr[g]  = bus.req_cmd[g*4 +: 4];
        assign meta_arr[g] = bus.req_metadata[g*8 +: 8];
        assign addr_arr[g] = bus.req_pte_addr[g*PTE_ADDR_W +: PTE_ADDR_W];
    end

    // First requester at or above the round-robin pointer, wrapping around
    always_comb begin
        logic [CH_W:0] cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cand = {1'b0, rr_ptr_q} + (CH_W+1)'(i);
            if (cand >= (CH_W+1)'(CHANNELS)) begin
                cand = cand - (CH_W+1)'(CHANNELS);
            end
            if (!grant_found && bus.req_valid[cand[CH_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[CH_W-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst_n && state_q == STATE_IDLE && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    armleocpu_pagefault_rules #(
        .HW_AD_UPDATE (HW_AD_UPDATE)
    ) u_rules (
        .cmd       (cmd_q),
        .metadata  (meta_q),
        .csr       (csr_q),
        .cause     (rule_cause),
        .ad_needed (rule_ad_needed)
    );

    always_comb begin
        state_d          = state_q;
        rr_ptr_d         = rr_ptr_q;
        owner_d          = owner_q;
        cmd_d            = cmd_q;
        meta_d           = meta_q;
        pte_addr_d       = pte_addr_q;
        csr_d            = csr_q;
        resp_valid_d     = 1'b0;
        resp_pagefault_d = 1'b0;
        resp_cause_d     = ARMLEOCPU_PF_NONE;
        ad_valid_d       = ad_valid_q;
        ad_addr_d        = ad_addr_q;
        ad_set_dirty_d   = ad_set_dirty_q;

        case (state_q)
            STATE_IDLE: begin
                // CSRs are snapshotted so later changes cannot affect this check
                if (grant_found) begin
                    owner_d    = grant_idx;
                    cmd_d      = cmd_arr[grant_idx];
                    meta_d     = meta_arr[grant_idx];
                    pte_addr_d = addr_arr[grant_idx];
                    csr_d      = '{satp_mode: csr_satp_mode_r,
                                   mprv:      csr_mstatus_mprv,
                                   mxr:       csr_mstatus_mxr,
                                   sum:       csr_mstatus_sum,
                                   mpp:       csr_mstatus_mpp,
                                   privilege: csr_mcurrent_privilege};
                    rr_ptr_d   = (grant_idx == CH_W'(CHANNELS-1)) ? '0 : grant_idx + CH_W'(1);
                    state_d    = STATE_CHECK;
                end
            end
            STATE_CHECK: begin
                if (rule_ad_needed) begin
                    ad_valid_d     = 1'b1;
                    ad_addr_d      = pte_addr_q;
                    ad_set_dirty_d = (cmd_q == CACHE_CMD_STORE);
                    state_d        = STATE_AD_REQ;
                end else begin
                    resp_valid_d     = 1'b1;
                    resp_pagefault_d = (rule_cause != ARMLEOCPU_PF_NONE);
                    resp_cause_d     = rule_cause;
                    state_d          = STATE_RESP;
                end
            end
            STATE_AD_REQ: begin
                if (bus.ad_ready) begin
                    ad_valid_d = 1'b0;
                    state_d    = STATE_AD_WAIT;
                end
            end
            STATE_AD_WAIT: begin
                if (bus.ad_done) begin
                    resp_valid_d     = 1'b1;
                    resp_pagefault_d = bus.ad_err;
                    resp_cause_d     = bus.ad_err ? ARMLEOCPU_PF_AD_ERR : ARMLEOCPU_PF_NONE;
                    state_d          = STATE_RESP;
                end
            end
            STATE_RESP: begin
                state_d = STATE_IDLE;
            end
            default: begin
                state_d = STATE_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= STATE_IDLE;
            rr_ptr_q         <= '0;
            owner_q          <= '0;
            cmd_q            <= '0;
            meta_q           <= '0;
            pte_addr_q       <= '0;
            csr_q            <= '0;
            resp_valid_q     <= 1'b0;
            resp_pagefault_q <= 1'b0;
            resp_cause_q     <= '0;
            ad_valid_q       <= 1'b0;
            ad_addr_q        <= '0;
            ad_set_dirty_q   <= 1'b0;
        end else begin
            state_q          <= state_d;
            rr_ptr_q         <= rr_ptr_d;
            owner_q          <= owner_d;
            cmd_q            <= cmd_d;
            meta_q           <= meta_d;
            pte_addr_q       <= pte_addr_d;
            csr_q            <= csr_d;
            resp_valid_q     <= resp_valid_d;
            resp_pagefault_q <= resp_pagefault_d;
            resp_cause_q     <= resp_cause_d;
            ad_valid_q       <= ad_valid_d;
            ad_addr_q        <= ad_addr_d;
            ad_set_dirty_q   <= ad_set_dirty_d;
        end
    end

    assign bus.req_ready      = req_ready;
    assign bus.resp_valid     = resp_valid_q;
    assign bus.resp_channel   = owner_q;
    assign bus.resp_pagefault = resp_pagefault_q;
    assign bus.resp_cause     = resp_cause_q;
    assign bus.ad_valid       = ad_valid_q;
    assign bus.ad_addr        = ad_addr_q;
    assign bus.ad_set_dirty   = ad_set_dirty_q;

endmodule

// File: tb/tb_armleocpu_pagefault_unit.sv
// Self-checking bench: one unit without and one with hardware A/D update,
// driven with directed and random requests against a behavioural model.
module tb_armleocpu_pagefault_unit;
    import armleocpu_pagefault_unit_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        satp, mprv, mxr, sum;
    logic [1:0]  mpp, priv;
    logic        sel;
    logic [1:0]  drvValid;
    logic [7:0]  drvCmd;
    logic [15:0] drvMeta;
    logic [67:0] drvAddr;
    logic        adReady, adDone, adErr;

    int compared = 0;
    int mismatched = 0;

    armleocpu_pagefault_unit_if #(.CHANNELS(2), .PTE_ADDR_W(34)) bus0 ();
    armleocpu_pagefault_unit_if #(.CHANNELS(2), .PTE_ADDR_W(34)) bus1 ();

    assign bus0.req_valid    = sel ? 2'b00 : drvValid;
    assign bus1.req_valid    = sel ? drvValid : 2'b00;
    assign bus0.req_cmd      = drvCmd;
    assign bus1.req_cmd      = drvCmd;
    assign bus0.req_metadata = drvMeta;
    assign bus1.req_metadata = drvMeta;
    assign bus0.req_pte_addr = drvAddr;
    assign bus1.req_pte_addr = drvAddr;
    assign bus0.ad_ready     = adReady;
    assign bus1.ad_ready     = adReady;
    assign bus0.ad_done      = adDone;
    assign bus1.ad_done      = adDone;
    assign bus0.ad_err       = adErr;
    assign bus1.ad_err       = adErr;

    armleocpu_pagefault_unit #(.CHANNELS(2), .HW_AD_UPDATE(0), .PTE_ADDR_W(34)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .csr_satp_mode_r(satp), .csr_mstatus_mprv(mprv), .csr_mstatus_mxr(mxr),
        .csr_mstatus_sum(sum), .csr_mstatus_mpp(mpp), .csr_mcurrent_privilege(priv),
        .bus(bus0)
    );

    armleocpu_pagefault_unit #(.CHANNELS(2), .HW_AD_UPDATE(1), .PTE_ADDR_W(34)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .csr_satp_mode_r(satp), .csr_mstatus_mprv(mprv), .csr_mstatus_mxr(mxr),
        .csr_mstatus_sum(sum), .csr_mstatus_mpp(mpp), .csr_mcurrent_privilege(priv),
        .bus(bus1)
    );

    logic [1:0]  obsReady;
    logic        obsRespValid, obsRespChannel, obsPf, obsAdValid, obsDirty;
    logic [2:0]  obsCause;
    logic [33:0] obsAddr;

    assign obsReady       = sel ? bus1.req_ready      : bus0.req_ready;
    assign obsRespValid   = sel ? bus1.resp_valid     : bus0.resp_valid;
    assign obsRespChannel = sel ? bus1.resp_channel   : bus0.resp_channel;
    assign obsPf          = sel ? bus1.resp_pagefault : bus0.resp_pagefault;
    assign obsCause       = sel ? bus1.resp_cause     : bus0.resp_cause;
    assign obsAdValid     = sel ? bus1.ad_valid       : bus0.ad_valid;
    assign obsAddr        = sel ? bus1.ad_addr        : bus0.ad_addr;
    assign obsDirty       = sel ? bus1.ad_set_dirty   : bus0.ad_set_dirty;

    // Every comparison funnels through here so the counts stay honest
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Sv32 rules written straight from the privilege architecture, evaluated in order
    function automatic int refCause(input logic [3:0] cmd, input logic [7:0] meta, input bit hw, output bit adNeeded);
        bit v = meta[0], r = meta[1], w = meta[2], x = meta[3], u = meta[4], a = meta[6], d = meta[7];
        int eff = (mprv && cmd != 4'd1) ? int'(mpp) : int'(priv);
        bit isExec = (cmd == 4'd1), isLoad = (cmd == 4'd2), isStore = (cmd == 4'd3);
        adNeeded = 1'b0;
        if (!satp || eff == 3 || cmd == 4'd0) return 0;
        if (!v || (w && !r)) return 1;
        if (u && eff == 1 && (!sum || isExec)) return 2;
        if (!u && eff == 0) return 2;
        if ((isExec && !x) || (isLoad && !(r || (mxr && x))) || (isStore && !w)) return 3;
        if (hw) begin
            adNeeded = !a || (isStore && !d);
            return 0;
        end
        if (!a) return 4;
        if (isStore && !d) return 5;
        return 0;
    endfunction

    task automatic setCsr(input bit s, input bit mp, input bit mx, input bit su, input logic [1:0] pp, input logic [1:0] pr);
        satp = s; mprv = mp; mxr = mx; sum = su; mpp = pp; priv = pr;
    endtask

    // Issue one request on channel ch starting at the current negedge, then follow it to its response
    task automatic applyStimulus(input int ch, input logic [3:0] cmd, input logic [7:0] meta, input logic [33:0] addr,
                                 input int readyDelay, input int doneDelay, input bit errIn);
        bit expAd;
        int expCause;
        expCause = refCause(cmd, meta, sel, expAd);
        drvValid = (ch == 0) ? 2'b01 : 2'b10;
        if (ch == 0) begin drvCmd[3:0] = cmd; drvMeta[7:0]  = meta; drvAddr[33:0]  = addr; end
        else         begin drvCmd[7:4] = cmd; drvMeta[15:8] = meta; drvAddr[67:34] = addr; end
        #1;
        checkOutput("req_ready", 64'(obsReady), 64'(drvValid));
        @(negedge clk);
        drvValid = 2'b00;
        setCsr(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom));
        checkOutput("resp_early", 64'(obsRespValid), 64'd0);
        @(negedge clk);
        if (expAd) begin
            checkOutput("ad_valid", 64'(obsAdValid), 64'd1);
            checkOutput("ad_addr", 64'(obsAddr), 64'(addr));
            checkOutput("ad_dirty", 64'(obsDirty), 64'(cmd == CACHE_CMD_STORE));
            for (int i = 0; i < readyDelay; i++) begin
                @(negedge clk);
                checkOutput("ad_hold", 64'({obsAdValid, obsAddr}), 64'({1'b1, addr}));
            end
            adReady = 1'b1;
            @(negedge clk);
            adReady = 1'b0;
            checkOutput("ad_drop", 64'(obsAdValid), 64'd0);
            for (int i = 0; i < doneDelay; i++) begin
                @(negedge clk);
                checkOutput("resp_wait", 64'(obsRespValid), 64'd0);
            end
            adDone = 1'b1;
            adErr  = errIn;
            @(negedge clk);
            adDone = 1'b0;
            adErr  = 1'b0;
            expCause = errIn ? 6 : 0;
        end else begin
            checkOutput("no_ad", 64'(obsAdValid), 64'd0);
        end
        checkOutput("resp_valid", 64'(obsRespValid), 64'd1);
        checkOutput("resp_channel", 64'(obsRespChannel), 64'(ch));
        checkOutput("resp_pagefault", 64'(obsPf), 64'(expCause != 0));
        checkOutput("resp_cause", 64'(obsCause), 64'(expCause));
        @(negedge clk);
        checkOutput("resp_pulse", 64'(obsRespValid), 64'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int grants[$];
        int owners[$];
        rst_n = 1'b0; sel = 1'b0;
        drvValid = 2'b11; drvCmd = '0; drvMeta = '0; drvAddr = '0;
        adReady = 1'b0; adDone = 1'b0; adErr = 1'b0;
        setCsr(1, 0, 0, 0, 2'd0, 2'd3);
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            checkOutput("reset_ready", 64'(obsReady), 64'd0);
            checkOutput("reset_outs", 64'({obsRespValid, obsPf, obsCause, obsAdValid, obsDirty}), 64'd0);
            checkOutput("reset_addr", 64'(obsAddr), 64'd0);
        end
        drvValid = 2'b00; sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] directed checks, A/D faulting unit");
        setCsr(1, 0, 0, 0, 2'd0, ARMLEOCPU_PRIVILEGE_MACHINE);
        applyStimulus(0, CACHE_CMD_STORE, 8'h00, 34'h0, 0, 0, 0);
        setCsr(1, 0, 0, 0, 2'd0, ARMLEOCPU_PRIVILEGE_SUPERVISOR);
        applyStimulus(1, CACHE_CMD_LOAD, 8'hDF, 34'h0, 0, 0, 0);
        setCsr(1, 0, 0, 1, 2'd0, ARMLEOCPU_PRIVILEGE_SUPERVISOR);
        applyStimulus(0, CACHE_CMD_LOAD, 8'hDF, 34'h0, 0, 0, 0);
        setCsr(1, 0, 0, 1, 2'd0, ARMLEOCPU_PRIVILEGE_SUPERVISOR);
        applyStimulus(1, CACHE_CMD_EXECUTE, 8'hDF, 34'h0, 0, 0, 0);
        setCsr(1, 0, 1, 0, 2'd0, ARMLEOCPU_PRIVILEGE_USER);
        applyStimulus(0, CACHE_CMD_LOAD, 8'hD9, 34'h0, 0, 0, 0);
        setCsr(1, 0, 0, 0, 2'd0, ARMLEOCPU_PRIVILEGE_USER);
        applyStimulus(0, CACHE_CMD_LOAD, 8'hD9, 34'h0, 0, 0, 0);
        setCsr(1, 0, 0, 0, 2'd0, ARMLEOCPU_PRIVILEGE_USER);
        applyStimulus(1, CACHE_CMD_STORE, 8'h5F, 34'h0, 0, 0, 0);
        setCsr(1, 0, 0, 0, 2'd0, ARMLEOCPU_PRIVILEGE_USER);
        applyStimulus(0, CACHE_CMD_LOAD, 8'h9F, 34'h0, 0, 0, 0);

        $display("[TB] round-robin with both channels requesting");
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        setCsr(1, 0, 0, 0, 2'd0, ARMLEOCPU_PRIVILEGE_MACHINE);
        drvCmd = {CACHE_CMD_LOAD, CACHE_CMD_LOAD};
        drvValid = 2'b11;
        for (int i = 0; i < 12; i++) begin
            #1;
            checkOutput("ready_onehot", 64'($countones(obsReady) <= 1), 64'd1);
            if (obsReady != 2'b00) grants.push_back(obsReady[1] ? 1 : 0);
            if (obsRespValid) begin
                if (owners.size() == 0) checkOutput("rr_spurious_resp", 64'd1, 64'd0);
                else checkOutput("rr_resp_channel", 64'(obsRespChannel), 64'(owners.pop_front()));
            end
            if (obsReady != 2'b00) owners.push_back(obsReady[1] ? 1 : 0);
            @(negedge clk);
        end
        drvValid = 2'b00;
        checkOutput("rr_grant_count", 64'(grants.size()), 64'd4);
        for (int i = 0; i < grants.size(); i++) begin
            checkOutput("rr_grant_order", 64'(grants[i]), 64'(i % 2));
        end
        checkOutput("rr_all_responded", 64'(owners.size()), 64'd0);
        @(negedge clk);

        $display("[TB] directed checks, hardware A/D unit");
        sel = 1'b1;
        setCsr(1, 0, 0, 0, 2'd0, ARMLEOCPU_PRIVILEGE_USER);
        applyStimulus(0, CACHE_CMD_STORE, 8'h5F, 34'h1000, 2, 1, 0);
        setCsr(1, 0, 0, 0, 2'd0, ARMLEOCPU_PRIVILEGE_USER);
        applyStimulus(1, CACHE_CMD_STORE, 8'h5F, 34'h1000, 0, 3, 1);
        setCsr(1, 0, 0, 0, 2'd0, ARMLEOCPU_PRIVILEGE_USER);
        applyStimulus(0, CACHE_CMD_LOAD, 8'h9F, 34'h2_3456_7890, 1, 0, 0);

        adDone = 1'b1; adErr = 1'b1;
        @(negedge clk);
        adDone = 1'b0; adErr = 1'b0;
        checkOutput("idle_ad_done_ignored", 64'(obsRespValid), 64'd0);

        $display("[TB] reset during A/D wait");
        setCsr(1, 0, 0, 0, 2'd0, ARMLEOCPU_PRIVILEGE_USER);
        drvValid = 2'b01; drvCmd[3:0] = CACHE_CMD_STORE; drvMeta[7:0] = 8'h5F; drvAddr[33:0] = 34'h3000;
        @(negedge clk);
        drvValid = 2'b00;
        @(negedge clk);
        checkOutput("rst_pre_ad_valid", 64'(obsAdValid), 64'd1);
        adReady = 1'b1;
        @(negedge clk);
        adReady = 1'b0;
        rst_n = 1'b0;
        adDone = 1'b1;
        @(negedge clk);
        checkOutput("rst_ad_valid", 64'(obsAdValid), 64'd0);
        checkOutput("rst_resp_valid", 64'(obsRespValid), 64'd0);
        adDone = 1'b0;
        rst_n = 1'b1;
        setCsr(1, 0, 0, 0, 2'd0, ARMLEOCPU_PRIVILEGE_MACHINE);
        applyStimulus(1, CACHE_CMD_LOAD, 8'h00, 34'h0, 0, 0, 0);

        $display("[TB] randomized traffic");
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            for (int n = 0; n < 40; n++) begin
                setCsr(($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
                       2'($urandom), 2'($urandom));
                applyStimulus($urandom_range(0, 1), 4'($urandom_range(0, 3)), 8'($urandom),
                              34'({$urandom, $urandom}), $urandom_range(0, 3), $urandom_range(0, 3),
                              1'($urandom));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/armleocpu_pagefault_unit.md
Name: armleocpu_pagefault_unit

Overview:
- Multi-channel, registered page-permission checker for the ArmleoCPU MMU path, sitting between the TLB read stage and the cache response logic.
- Arbitrates translated-access checks from CHANNELS requesters (e.g. fetch and data) using round-robin.
- Evaluates RISC-V Sv32 permission rules on the 8-bit PTE metadata and returns a pagefault flag plus a cause code.
- With HW_AD_UPDATE=1, handles clear A bits and clear D bits on stores through a PTE update handshake instead of faulting.

Parameters:
- CHANNELS, 2, number of requesters; legal range 1..4.
- HW_AD_UPDATE, 0, 1 = hardware A/D update; 0 = A/D violations fault.
- PTE_ADDR_W, 34, physical address width of the PTE update address.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- req_valid  in  CHANNELS  per-channel request valid.
- req_ready  out  CHANNELS  per-channel accept; one-hot or zero.
- req_cmd  in  CHANNELS*4  CACHE_CMD_* per channel.
- req_metadata  in  CHANNELS*8  PTE bits D,A,G,U,X,W,R,V (bit 7..0).
- req_pte_addr  in  CHANNELS*PTE_ADDR_W  PTE physical address, used for the A/D update.
- csr_satp_mode_r, csr_mstatus_mprv, csr_mstatus_mxr, csr_mstatus_sum  in  1 each.
- csr_mstatus_mpp, csr_mcurrent_privilege  in  2 each.
- resp_valid  out  1  one-cycle response pulse; no backpressure.
- resp_channel  out  max(1,$clog2(CHANNELS))  channel that owns the response.
- resp_pagefault  out  1.
- resp_cause  out  3  PF cause code.
- ad_valid  out  1  PTE update request.
- ad_ready  in  1.
- ad_addr  out  PTE_ADDR_W.
- ad_set_dirty  out  1  1 = set A and D; 0 = set A only.
- ad_done  in  1  update completion pulse.
- ad_err  in  1  qualified by ad_done.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, RR pointer=0.
  - All outputs 0: req_ready, resp_*, ad_valid, ad_addr, ad_set_dirty.
- Reset mid-operation: abandons any transaction. No resp_valid is issued. ad_valid drops on the next edge.
- IDLE state:
  - Grant = first channel with req_valid, searching upward from the RR pointer and wrapping.
  - req_ready is high only for the granted channel.
  - On handshake: capture cmd, metadata, pte_addr and all csr_* inputs; pointer = grant+1 (mod CHANNELS); go to CHECK.
  - CSR changes after acceptance do not affect the in-flight check.
- CHECK state (1 cycle): evaluate rules on the captured values.
  - If an A/D update is needed and HW_AD_UPDATE=1, go to AD_REQ.
  - Otherwise register the result and go to RESP.
- Rules: effective privilege = mpp if (mprv && cmd!=EXECUTE), else current privilege. Cause priority, first match wins:
  - No fault (cause 0): satp_mode=0, or effective privilege=MACHINE, or cmd=NONE.
  - Cause 1, invalid PTE: !V, or (W && !R).
  - Cause 2, privilege: U=1 page with supervisor and (!sum or EXECUTE); or U=0 page with user privilege.
  - Cause 3, permission:
    - EXECUTE requires X.
    - LOAD requires R, or (mxr && X).
    - STORE requires W.
  - Cause 4: A=0 and HW_AD_UPDATE=0.
  - Cause 5: STORE with D=0 and HW_AD_UPDATE=0.
  - A/D update is needed when no earlier cause hit and (A=0, or STORE with D=0).
    - ad_set_dirty = (cmd==STORE).
- AD_REQ state:
  - ad_valid=1 and ad_addr is stable until ad_ready is high at a clk edge; then go to AD_WAIT.
- AD_WAIT state:
  - Wait for ad_done.
  - ad_err=1: resp_pagefault=1, cause 6.
  - ad_err=0: no fault, cause 0.
  - Then go to RESP.
  - ad_done seen in any other state is ignored.
- RESP state: resp_valid=1 for exactly one cycle with resp_channel, resp_pagefault and resp_cause; then go to IDLE.
- Latency:
  - Request accepted in cycle T gives resp_valid in cycle T+2.
  - With an A/D update: T+2 + ad_ready wait + ad_done wait + 1.
- Throughput: one transaction in flight; req_ready is 0 outside IDLE.
- resp_cause is 0 whenever resp_pagefault=0.

Decomposition:
- Into armleocpu_defines.vh:
  - PF cause localparams ARMLEOCPU_PF_NONE..ARMLEOCPU_PF_AD_ERR (0..6).
  - PTE metadata bit indices (V=0..D=7).
  - Existing CACHE_CMD_* and ARMLEOCPU_PRIVILEGE_* values are reused.
- Sub-module armleocpu_pagefault_rules: purely combinational cause evaluation. It is instantiated by the CHECK stage and unit-testable alone.
- The FSM and arbiter stay in the top module.

Test Plan:
- Machine mode, satp_mode=1, STORE, metadata 8'h00 on ch0 -> resp_valid at T+2, pagefault=0, cause 0.
- Supervisor, sum=0, LOAD, metadata 8'hDF -> pagefault=1, cause 2. Same with sum=1 -> pagefault=0. sum=1 with EXECUTE -> cause 2.
- User, LOAD, metadata 8'hD9 (X only): mxr=1 -> pagefault=0; mxr=0 -> pagefault=1, cause 3.
- HW_AD_UPDATE=0: STORE with 8'h5F -> cause 5; LOAD with 8'h9F -> cause 4. HW_AD_UPDATE=1: STORE with 8'h5F, pte_addr 34'h1000 -> ad_valid with ad_addr=34'h1000 and ad_set_dirty=1.
  - ad_done with ad_err=0 -> pagefault=0.
  - ad_done with ad_err=1 -> pagefault=1, cause 6.
- CHANNELS=2, both req_valid held high -> grants alternate ch0, ch1, ch0. resp_channel matches. req_ready is never high for both channels at once.
- rst_n low during AD_WAIT -> no resp_valid. ad_valid=0 and state=IDLE after the edge. A new request is accepted in the first cycle after rst_n rises.
